// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image-pipeline FSM states, size defaults and width helper
package img_pkg;

    localparam int IMG_ROW_DEF = 540;
    localparam int IMG_COL_DEF = 540;
    localparam int DATA_W_DEF  = 8;
    localparam int DBG_W       = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    // Bits needed to hold any value in 0..n (a counter that can reach n).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) w++;
        return w;
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - synchronous pixel FIFO with occupancy count, async active-low reset
module pix_fifo
    import img_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] data,
    output logic [CW-1:0]     count,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_pop;

    assign do_pop = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_pop)      count <= count + 1'b1;
            else if (!push && do_pop) count <= count - 1'b1;
        end
    end

    assign data  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/img_fetch_ctrl.sv
// rtl/img_fetch_ctrl.sv - row-major BRAM image streamer with credit-managed output FIFO
// Optional one-pixel zero border when BORDER_PAD_EN is defined.
module img_fetch_ctrl
    import img_pkg::*;
#(
    parameter int IMG_ROW  = IMG_ROW_DEF,
    parameter int IMG_COL  = IMG_COL_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 1,
    parameter int FIFO_DEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] d2mem_o,
    input  logic [DATA_W-1:0] mem2d_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_en_o,
    input  logic              data_rdy_i,
    input  logic              fetch_run_i,
    output logic              fetch_done_o,
    output logic [DBG_W-1:0]  cnt_img_row_o,
    output logic [DBG_W-1:0]  cnt_img_col_o
);

`ifdef BORDER_PAD_EN
    localparam int N_ROWS = IMG_ROW + 2;
    localparam int N_COLS = IMG_COL + 2;
`else
    localparam int N_ROWS = IMG_ROW;
    localparam int N_COLS = IMG_COL;
`endif
    localparam int               CW       = cnt_width(FIFO_DEP);
    localparam logic [DBG_W-1:0] LAST_ROW = DBG_W'(N_ROWS - 1);
    localparam logic [DBG_W-1:0] LAST_COL = DBG_W'(N_COLS - 1);
    localparam logic [CW:0]      DEP_C    = (CW+1)'(FIFO_DEP);

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [DBG_W-1:0]  row;
    logic [DBG_W-1:0]  col;
    logic [ADDR_W-1:0] addr;
    logic [RD_LAT-1:0] iss_sr;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic              credit_ok;
    logic              issue;
    logic              rd_en;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    // Every issued beat owns a FIFO slot until popped, so the FIFO can never overflow.
    assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, inflight}) < DEP_C;
    assign push      = iss_sr[RD_LAT-1];
    assign pop       = data_rdy_i && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        issue        = 1'b0;
        fetch_done_o = 1'b0;
        case (state)
            ST_IDLE:  if (fetch_run_i) state_nx = ST_FETCH;
            ST_FETCH: begin
                issue = credit_ok;
                if (credit_ok && row == LAST_ROW && col == LAST_COL) state_nx = ST_DRAIN;
            end
            ST_DRAIN: if (inflight == '0 && fifo_empty) state_nx = ST_DONE;
            ST_DONE: begin
                fetch_done_o = 1'b1;
                state_nx     = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (state == ST_IDLE) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (issue) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            if (rd_en) addr <= addr + 1'b1;
        end
    end

    // Issue flag travels alongside the BRAM pipeline to mark when mem2d_i is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_sr   <= '0;
            inflight <= '0;
        end else begin
            iss_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) iss_sr[i] <= iss_sr[i-1];
            if (issue && !push)      inflight <= inflight + 1'b1;
            else if (!issue && push) inflight <= inflight - 1'b1;
        end
    end

`ifdef BORDER_PAD_EN
    logic              interior;
    logic [RD_LAT-1:0] pad_sr;

    assign interior = (row != '0) && (row != LAST_ROW) && (col != '0) && (col != LAST_COL);
    assign rd_en    = issue && interior;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_sr <= '0;
        end else begin
            pad_sr[0] <= issue && !interior;
            for (int i = 1; i < RD_LAT; i++) pad_sr[i] <= pad_sr[i-1];
        end
    end

    assign push_data = pad_sr[RD_LAT-1] ? '0 : mem2d_i;
`else
    assign rd_en     = issue;
    assign push_data = mem2d_i;
`endif

    pix_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEP)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .data      (data_o),
        .count     (fifo_cnt),
        .empty     (fifo_empty)
    );

    assign ena_o         = rd_en;
    assign wea_o         = 1'b0;
    assign d2mem_o       = '0;
    assign addr_o        = addr;
    assign data_en_o     = !fifo_empty;
    assign cnt_img_row_o = row;
    assign cnt_img_col_o = col;

endmodule

// File: tb/tb_img_fetch_ctrl.sv
// tb/tb_img_fetch_ctrl.sv - directed bench for img_fetch_ctrl with RD_LAT=1 and RD_LAT=2 instances
module tb_img_fetch_ctrl;

`ifdef BORDER_PAD_EN
    localparam int R = 2;
    localparam int C = 2;
    localparam int N_ENA = 4;
`else
    localparam int R = 4;
    localparam int C = 4;
    localparam int N_ENA = 16;
`endif
    localparam int BEATS = 16;
    localparam int DEP   = 4;
    localparam int DW    = 8;
    localparam int AW    = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    logic          run   [2];
    logic          ena   [2];
    logic          wea   [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] d2mem [2];
    logic [DW-1:0] dout  [2];
    logic          den   [2];
    logic          done  [2];
    logic [9:0]    rowc  [2];
    logic [9:0]    colc  [2];
    logic [DW-1:0] bram    [16];
    logic [DW-1:0] exp_tab [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;

        always @(posedge clk) begin
            if (ena[g]) s1 <= bram[addr[g][3:0]];
            s2 <= s1;
        end

        img_fetch_ctrl #(
            .IMG_ROW (R), .IMG_COL (C), .DATA_W (DW), .ADDR_W (AW),
            .RD_LAT (g + 1), .FIFO_DEP (DEP)
        ) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .ena_o         (ena[g]),
            .wea_o         (wea[g]),
            .addr_o        (addr[g]),
            .d2mem_o       (d2mem[g]),
            .mem2d_i       (g == 0 ? s1 : s2),
            .data_o        (dout[g]),
            .data_en_o     (den[g]),
            .data_rdy_i    (rdy),
            .fetch_run_i   (run[g]),
            .fetch_done_o  (done[g]),
            .cnt_img_row_o (rowc[g]),
            .cnt_img_col_o (colc[g])
        );
    end

    int            checks = 0;
    int            errors = 0;
    int            sel = 0;
    int            cyc = 0;
    bit            toggle_mode = 1'b0;
    int            pat_idx = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] beats [$];
    int            ena_cnt, done_cnt, max_out, first_cyc, last_cyc;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ready pattern and beat capture live on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        cyc++;
        if (toggle_mode) begin
            rdy = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
            pat_idx++;
        end else begin
            rdy = 1'b1;
        end
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_hold_en", den[sel], 1);
                check("stall_hold_data", dout[sel], prev_data);
            end
            if (ena[sel]) begin
                ena_cnt++;
                if (ena_cnt - beats.size() > max_out) max_out = ena_cnt - beats.size();
            end
            if (den[sel] && rdy) begin
                beats.push_back(dout[sel]);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            prev_stall = den[sel] && !rdy;
            prev_data  = dout[sel];
            if (done[sel]) done_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int s, input int lat_exp, input bit hold, input string tag);
        int lat;
        sel = s;
        beats.delete();
        ena_cnt   = 0;
        done_cnt  = 0;
        max_out   = 0;
        first_cyc = -1;
        pat_idx   = 0;
        run[s]    = 1'b1;
        lat       = 0;
        do begin
            tick(1);
            lat++;
            if (!hold) run[s] = 1'b0;
        end while (!den[s] && lat < 20);
        check({tag, "_latency"}, lat, lat_exp);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done[sel] && n < 300) begin
            tick(1);
            n++;
        end
        check({tag, "_done_seen"}, done[sel], 1);
        check({tag, "_dbg_row"}, rowc[sel], 4);
        check({tag, "_dbg_col"}, colc[sel], 0);
    endtask

    task automatic verify(input string tag, input int frames, input bit gapless);
        tick(3);
        check({tag, "_done_pulses"}, done_cnt, frames);
        check({tag, "_beat_count"}, beats.size(), frames * BEATS);
        check({tag, "_ena_count"}, ena_cnt, frames * N_ENA);
        check({tag, "_credit"}, (max_out <= DEP), 1);
        for (int i = 0; i < beats.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), beats[i], exp_tab[i % BEATS]);
        if (gapless) check({tag, "_gapless"}, last_cyc - first_cyc, BEATS - 1);
    endtask

    task automatic check_idle_outputs(input int s, input string tag);
        check({tag, "_ena"}, ena[s], 0);
        check({tag, "_wea"}, wea[s], 0);
        check({tag, "_addr"}, addr[s], 0);
        check({tag, "_d2mem"}, d2mem[s], 0);
        check({tag, "_data"}, dout[s], 0);
        check({tag, "_data_en"}, den[s], 0);
        check({tag, "_done"}, done[s], 0);
        check({tag, "_row"}, rowc[s], 0);
        check({tag, "_col"}, colc[s], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef BORDER_PAD_EN
        exp_tab = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0,
                    8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 16; i++) bram[i] = (i < 4) ? DW'(i + 1) : 8'hEE;
`else
        for (int i = 0; i < 16; i++) begin
            exp_tab[i] = DW'(i);
            bram[i]    = DW'(i);
        end
`endif
        rst_n  = 1'b0;
        run[0] = 1'b0;
        run[1] = 1'b0;
        tick(3);
        check_idle_outputs(0, "reset0");
        check_idle_outputs(1, "reset1");
        rst_n = 1'b1;
        tick(2);

        // T1 / T5: RD_LAT=1, ready held high
        start_frame(0, 3, 1'b0, "t1");
        wait_done("t1");
        verify("t1", 1, 1'b1);

        // T2: RD_LAT=2
        start_frame(1, 4, 1'b0, "t2");
        wait_done("t2");
        verify("t2", 1, 1'b1);

        // T3: ready toggling 1,0,0,1 on both latencies
        toggle_mode = 1'b1;
        start_frame(0, 3, 1'b0, "t3a");
        wait_done("t3a");
        verify("t3a", 1, 1'b0);
        start_frame(1, 4, 1'b0, "t3b");
        wait_done("t3b");
        verify("t3b", 1, 1'b0);
        toggle_mode = 1'b0;

        // T4: reset mid-frame then rerun
        start_frame(0, 3, 1'b0, "t4");
        for (int n = 0; n < 100 && beats.size() < 7; n++) tick(1);
        check("t4_reached_beat7", (beats.size() >= 7), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "t4_abort");
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("t4_no_done", done_cnt, 0);
        check("t4_idle_after", den[0], 0);
        start_frame(0, 3, 1'b0, "t4r");
        wait_done("t4r");
        verify("t4r", 1, 1'b1);

        // T6: run held across DONE gives back-to-back frames, one pulse each
        start_frame(1, 4, 1'b1, "t6");
        wait_done("t6f1");
        for (int n = 0; n < 10 && done[1]; n++) tick(1);
        wait_done("t6f2");
        run[1] = 1'b0;
        verify("t6", 2, 1'b0);
        tick(10);
        check("t6_no_third", den[1], 0);
        check("t6_ena_total", ena_cnt, 2 * N_ENA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
